fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Sits directly downstream of the EX-stage branch/jump resolution logic. Consumes its 2-bit PCSrcE select together with the EX-stage targets.
- Holds the PC and selects the next PC; the instruction memory is addressed by PCF.
- Registers the instruction into D, handling hazard-unit stalls, redirect flushes and a redirect counter.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into InstrD on flush/reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCSrcE  input  2  next-PC select: 00 PC+4, 01 branch/JAL target, 10 JALR target, 11 reserved.
- PCTargetE  input  32  PC-relative target from EX (branch/JAL).
- ALUResultE  input  32  JALR target from EX ALU.
- StallF  input  1  hazard unit: hold PC.
- StallD  input  1  hazard unit: hold IF/ID register.
- FlushD  input  1  hazard unit: external flush of IF/ID.
- InstrF  input  32  instruction memory read data for address PCF (combinational, same cycle).
- PCF  output  32  current fetch PC, drives instruction memory address.
- PCPlus4F  output  32  PCF + 4, combinational.
- InstrD  output  32  registered instruction in D.
- PCD  output  32  registered PC of InstrD.
- PCPlus4D  output  32  registered PCF+4 of InstrD.
- ValidD  output  1  1 = InstrD is a real fetched instruction, 0 = bubble.
- RedirectE  output  1  combinational, 1 when PCSrcE is 01 or 10.
- RedirectCount  output  32  number of redirects taken since reset.

Behaviour:
- Reset (async, rst=1):
  - PCF=RESET_PC.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, RedirectCount=0.
  - All hold while rst is high; first fetch is from RESET_PC on the first edge after deassertion.
- Next-PC mux (combinational):
  - 00 or 11 -> PCF+4.
  - 01 -> PCTargetE.
  - 10 -> {ALUResultE[31:1],1'b0} (JALR LSB cleared).
  - 11 is treated as no redirect: RedirectE=0 and no count.
- Adders: 32-bit, wrap modulo 2^32 (PCF=32'hFFFF_FFFC gives PCPlus4F=0); no overflow flag.
- PC register, each rising edge, in priority order:
  - RedirectE=1 -> load the selected target, even if StallF=1. Redirect wins because the younger F instruction is wrong-path.
  - Else StallF=1 -> hold.
  - Else load PCF+4.
- IF/ID register, each rising edge, in priority order:
  - FlushD=1 or RedirectE=1 -> InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D=0. Flush wins over StallD.
  - Else StallD=1 -> hold all D outputs, ValidD included.
  - Else capture InstrF, PCF, PCPlus4F; ValidD=1.
- Redirect penalty:
  - Redirect seen in cycle N: PCF equals the target in cycle N+1, and D holds a bubble in cycle N+1.
  - The target instruction reaches D in cycle N+2.
  - Flushing E is the hazard unit's job, outside this block.
- RedirectCount: increments by 1 on each edge with RedirectE=1 and rst=0, independent of stalls; wraps at 2^32.
- Latency: InstrF to InstrD is one cycle; PCF updates one cycle after its select.
- Reset mid-operation: asynchronous clear, no partial update; pending redirect is discarded.

Test Plan:
- Reset, then 4 free-running cycles, PCSrcE=00, no stalls -> PCF sequence 0,4,8,C. InstrD lags InstrF by one cycle; ValidD rises on the first edge after reset.
- At PCF=0x10: PCSrcE=01, PCTargetE=0x100 for one cycle -> next PCF=0x100, InstrD=0x00000013, ValidD=0. Next cycle InstrD=mem[0x100], PCD=0x100. RedirectCount=1.
- PCSrcE=10, ALUResultE=0x0000_0203 -> PCF=0x202, RedirectE=1, D flushed.
- StallF=StallD=1 for 2 cycles at PCF=0x20 -> PCF, InstrD, PCD, ValidD unchanged. On release PCF=0x24.
- StallF=1, StallD=1, PCSrcE=01, PCTargetE=0x40 in the same cycle -> PCF=0x40 and D flushed (redirect beats stall). FlushD=1 with StallD=1 and no redirect -> D bubble, PCF held.
- PCF=0xFFFF_FFFC, no redirect -> PCF wraps to 0. PCSrcE=11 -> PC+4, RedirectE=0, count unchanged. Assert rst mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID pipeline register.
// Holds the fetch PC, picks the next PC from the EX-stage redirect select,
// and registers the fetched instruction into D with stall, flush and bubble
// handling. It also counts redirects taken since reset.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  PCSrcE,
   input  logic [31:0] PCTargetE,
   input  logic [31:0] ALUResultE,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        RedirectE,
   output logic [31:0] RedirectCount
);

   logic [31:0] pc_next;

   // Sequential PC plus 4; the 32-bit sum wraps naturally.
   assign PCPlus4F = PCF + 32'd4;

   // Next-PC select; code 11 is reserved and behaves like plain PC+4.
   always_comb begin
      pc_next   = PCPlus4F;
      RedirectE = 1'b0;
      unique case (PCSrcE)
         2'b01: begin
            pc_next   = PCTargetE;
            RedirectE = 1'b1;
         end
         2'b10: begin
            pc_next   = {ALUResultE[31:1], 1'b0};
            RedirectE = 1'b1;
         end
         default: begin
            pc_next   = PCPlus4F;
            RedirectE = 1'b0;
         end
      endcase
   end

   // PC register: a redirect wins over a stall because whatever sits in F
   // behind a taken redirect is wrong-path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PCF <= RESET_PC;
      end else if (RedirectE) begin
         PCF <= pc_next;
      end else if (!StallF) begin
         PCF <= PCPlus4F;
      end
   end

   // IF/ID register: a flush (external or from a redirect) inserts a bubble
   // even when D is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (FlushD || RedirectE) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'd0;
         PCPlus4D <= 32'd0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= InstrF;
         PCD      <= PCF;
         PCPlus4D <= PCPlus4F;
         ValidD   <= 1'b1;
      end
   end

   // Redirect counter; counts regardless of stalls and wraps at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RedirectCount <= 32'd0;
      end else if (RedirectE) begin
         RedirectCount <= RedirectCount + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. A combinational instruction memory
// returns a fixed address-derived word so every fetched instruction is
// distinguishable from the bubble and from its neighbours.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] ALUResultE;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic        RedirectE;
   logic [31:0] RedirectCount;

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], 16'h0033} ^ 32'h5A5A_0000;
   endfunction

   assign InstrF = mem(PCF);

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .RedirectE(RedirectE), .RedirectCount(RedirectCount)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; PCSrcE = 2'b00; PCTargetE = '0; ALUResultE = '0;
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      step(); step();
      vectors++; if (PCF !== 32'h0) begin miscompares++; $display("FAIL reset_pcf got %h want %h", PCF, 32'h0); end
      vectors++; if (InstrD !== NOP) begin miscompares++; $display("FAIL reset_instrd got %h want %h", InstrD, NOP); end
      vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL reset_validd got %b want 0", ValidD); end
      vectors++; if (RedirectCount !== 32'h0) begin miscompares++; $display("FAIL reset_count got %h want 0", RedirectCount); end
      vectors++; if ({PCD, PCPlus4D} !== 64'h0) begin miscompares++; $display("FAIL reset_pcd got %h/%h want 0/0", PCD, PCPlus4D); end
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      step();
      vectors++; if (PCF !== 32'h4) begin miscompares++; $display("FAIL run_pcf1 got %h want %h", PCF, 32'h4); end
      vectors++; if (InstrD !== mem(32'h0)) begin miscompares++; $display("FAIL run_instrd1 got %h want %h", InstrD, mem(32'h0)); end
      vectors++; if (ValidD !== 1'b1) begin miscompares++; $display("FAIL run_validd1 got %b want 1", ValidD); end
      vectors++; if ({PCD, PCPlus4D} !== {32'h0, 32'h4}) begin miscompares++; $display("FAIL run_pcd1 got %h/%h want 0/4", PCD, PCPlus4D); end
      step();
      vectors++; if (PCF !== 32'h8) begin miscompares++; $display("FAIL run_pcf2 got %h want %h", PCF, 32'h8); end
      vectors++; if (InstrD !== mem(32'h4)) begin miscompares++; $display("FAIL run_instrd2 got %h want %h", InstrD, mem(32'h4)); end
      step();
      vectors++; if (PCF !== 32'hC) begin miscompares++; $display("FAIL run_pcf3 got %h want %h", PCF, 32'hC); end
      vectors++; if (PCPlus4F !== 32'h10) begin miscompares++; $display("FAIL run_pcplus4f got %h want %h", PCPlus4F, 32'h10); end
      step();
      vectors++; if (PCF !== 32'h10) begin miscompares++; $display("FAIL run_pcf4 got %h want %h", PCF, 32'h10); end
      vectors++; if (PCD !== 32'hC) begin miscompares++; $display("FAIL run_pcd4 got %h want %h", PCD, 32'hC); end
   endtask

   task automatic test_branch_redirect();
      PCSrcE = 2'b01; PCTargetE = 32'h100;
      #1;
      vectors++; if (RedirectE !== 1'b1) begin miscompares++; $display("FAIL br_redirecte got %b want 1", RedirectE); end
      step();
      PCSrcE = 2'b00;
      vectors++; if (PCF !== 32'h100) begin miscompares++; $display("FAIL br_pcf got %h want %h", PCF, 32'h100); end
      vectors++; if (InstrD !== NOP) begin miscompares++; $display("FAIL br_instrd got %h want %h", InstrD, NOP); end
      vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL br_validd got %b want 0", ValidD); end
      vectors++; if (RedirectCount !== 32'd1) begin miscompares++; $display("FAIL br_count got %0d want 1", RedirectCount); end
      step();
      vectors++; if (InstrD !== mem(32'h100)) begin miscompares++; $display("FAIL br_target_instrd got %h want %h", InstrD, mem(32'h100)); end
      vectors++; if (PCD !== 32'h100) begin miscompares++; $display("FAIL br_target_pcd got %h want %h", PCD, 32'h100); end
      vectors++; if (ValidD !== 1'b1) begin miscompares++; $display("FAIL br_target_validd got %b want 1", ValidD); end
      vectors++; if (PCF !== 32'h104) begin miscompares++; $display("FAIL br_after_pcf got %h want %h", PCF, 32'h104); end
   endtask

   task automatic test_jalr_redirect();
      PCSrcE = 2'b10; ALUResultE = 32'h0000_0203; PCTargetE = 32'h0000_0777;
      #1;
      vectors++; if (RedirectE !== 1'b1) begin miscompares++; $display("FAIL jalr_redirecte got %b want 1", RedirectE); end
      step();
      PCSrcE = 2'b00;
      vectors++; if (PCF !== 32'h202) begin miscompares++; $display("FAIL jalr_pcf got %h want %h", PCF, 32'h202); end
      vectors++; if (ValidD !== 1'b0 || InstrD !== NOP) begin miscompares++; $display("FAIL jalr_flush got %b/%h want 0/%h", ValidD, InstrD, NOP); end
      vectors++; if (RedirectCount !== 32'd2) begin miscompares++; $display("FAIL jalr_count got %0d want 2", RedirectCount); end
   endtask

   task automatic test_stall();
      PCSrcE = 2'b01; PCTargetE = 32'h1C;
      step();
      PCSrcE = 2'b00;
      step();
      vectors++; if (PCF !== 32'h20 || InstrD !== mem(32'h1C)) begin miscompares++; $display("FAIL stall_setup got %h/%h want 20/%h", PCF, InstrD, mem(32'h1C)); end
      StallF = 1'b1; StallD = 1'b1;
      step(); step();
      vectors++; if (PCF !== 32'h20) begin miscompares++; $display("FAIL stall_pcf got %h want %h", PCF, 32'h20); end
      vectors++; if (InstrD !== mem(32'h1C)) begin miscompares++; $display("FAIL stall_instrd got %h want %h", InstrD, mem(32'h1C)); end
      vectors++; if (PCD !== 32'h1C || ValidD !== 1'b1) begin miscompares++; $display("FAIL stall_pcd got %h/%b want 1c/1", PCD, ValidD); end
      StallF = 1'b0; StallD = 1'b0;
      step();
      vectors++; if (PCF !== 32'h24) begin miscompares++; $display("FAIL stall_release_pcf got %h want %h", PCF, 32'h24); end
      vectors++; if (InstrD !== mem(32'h20) || PCD !== 32'h20) begin miscompares++; $display("FAIL stall_release_d got %h/%h want %h/20", InstrD, PCD, mem(32'h20)); end
      vectors++; if (RedirectCount !== 32'd3) begin miscompares++; $display("FAIL stall_count got %0d want 3", RedirectCount); end
   endtask

   task automatic test_redirect_beats_stall();
      StallF = 1'b1; StallD = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h40;
      step();
      PCSrcE = 2'b00;
      vectors++; if (PCF !== 32'h40) begin miscompares++; $display("FAIL rvs_pcf got %h want %h", PCF, 32'h40); end
      vectors++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0) begin miscompares++; $display("FAIL rvs_flush got %b/%h/%h want 0/%h/0", ValidD, InstrD, PCD, NOP); end
      vectors++; if (RedirectCount !== 32'd4) begin miscompares++; $display("FAIL rvs_count got %0d want 4", RedirectCount); end
      StallF = 1'b0; StallD = 1'b0;
      step();
      vectors++; if (PCF !== 32'h44 || ValidD !== 1'b1) begin miscompares++; $display("FAIL flush_setup got %h/%b want 44/1", PCF, ValidD); end
      StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
      step();
      vectors++; if (PCF !== 32'h44) begin miscompares++; $display("FAIL flush_pcf_held got %h want %h", PCF, 32'h44); end
      vectors++; if (ValidD !== 1'b0 || InstrD !== NOP || PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL flush_d got %b/%h/%h want 0/%h/0", ValidD, InstrD, PCPlus4D, NOP); end
      vectors++; if (RedirectCount !== 32'd4) begin miscompares++; $display("FAIL flush_count got %0d want 4", RedirectCount); end
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
   endtask

   task automatic test_wrap_and_reserved();
      PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;
      step();
      PCSrcE = 2'b00;
      vectors++; if (PCPlus4F !== 32'h0) begin miscompares++; $display("FAIL wrap_pcplus4f got %h want 0", PCPlus4F); end
      step();
      vectors++; if (PCF !== 32'h0) begin miscompares++; $display("FAIL wrap_pcf got %h want 0", PCF); end
      vectors++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL wrap_pcd got %h/%h want fffffffc/0", PCD, PCPlus4D); end
      PCSrcE = 2'b11; PCTargetE = 32'h500; ALUResultE = 32'h601;
      #1;
      vectors++; if (RedirectE !== 1'b0) begin miscompares++; $display("FAIL rsv_redirecte got %b want 0", RedirectE); end
      step();
      PCSrcE = 2'b00;
      vectors++; if (PCF !== 32'h4) begin miscompares++; $display("FAIL rsv_pcf got %h want 4", PCF); end
      vectors++; if (ValidD !== 1'b1 || InstrD !== mem(32'h0)) begin miscompares++; $display("FAIL rsv_d got %b/%h want 1/%h", ValidD, InstrD, mem(32'h0)); end
      vectors++; if (RedirectCount !== 32'd5) begin miscompares++; $display("FAIL rsv_count got %0d want 5", RedirectCount); end
   endtask

   task automatic test_async_reset();
      step();
      PCSrcE = 2'b01; PCTargetE = 32'h800;
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (PCF !== 32'h0) begin miscompares++; $display("FAIL arst_pcf got %h want 0", PCF); end
      vectors++; if (InstrD !== NOP || ValidD !== 1'b0) begin miscompares++; $display("FAIL arst_d got %h/%b want %h/0", InstrD, ValidD, NOP); end
      vectors++; if ({PCD, PCPlus4D} !== 64'h0) begin miscompares++; $display("FAIL arst_pcd got %h/%h want 0/0", PCD, PCPlus4D); end
      vectors++; if (RedirectCount !== 32'h0) begin miscompares++; $display("FAIL arst_count got %h want 0", RedirectCount); end
      step();
      vectors++; if (PCF !== 32'h0 || RedirectCount !== 32'h0) begin miscompares++; $display("FAIL arst_hold got %h/%h want 0/0", PCF, RedirectCount); end
      PCSrcE = 2'b00; rst = 1'b0;
      step();
      vectors++; if (PCF !== 32'h4 || InstrD !== mem(32'h0)) begin miscompares++; $display("FAIL arst_restart got %h/%h want 4/%h", PCF, InstrD, mem(32'h0)); end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_free_run();
      test_branch_redirect();
      test_jalr_redirect();
      test_stall();
      test_redirect_beats_stall();
      test_wrap_and_reserved();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
